protocore_datapath: RTL and testbench
=====================================

// Module: protocore_datapath
// PURPOSE
//  ProtoCore 8-bit datapath: 16x8 register file (R0 hardwired 0), 8-op ALU, write-back source mux.
//  Two async read ports feed the ALU; one synchronous write port takes ALU result, RAM load data or immediate.
//  Sits between control/decoder (addresses, opcode, enables) and data RAM; flags go to branch logic.
// PARAMETERS
//  DATA_W    8   register/ALU data width
//  NUM_REGS  16  register count; address width = clog2(NUM_REGS) = 4
// PORTS
//  clk           in   1  rising-edge clock
//  rst_n         in   1  asynchronous active-low reset
//  write_alu     in   1  write-back source = alu_out
//  alu_opcode    in   3  ALU operation
//  ram_data      in   8  load data from RAM
//  imm_data      in   8  immediate from instruction
//  write_addr    in   4  write-port register index
//  ra_addr       in   4  read port A index
//  rb_addr       in   4  read port B index
//  write_en      in   1  register write enable
//  is_load       in   1  write-back source = ram_data (when write_alu=0)
//  alu_imm_flag  in   1  ALU operand B = imm_data instead of read_b
//  read_a        out  8  port A read data (with bypass)
//  read_b        out  8  port B read data (with bypass)
//  alu_zero      out  1  alu_out == 0
//  alu_carry     out  1  carry/borrow/shifted-out bit
//  alu_out       out  8  ALU result
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers clear to 0x00; outputs follow combinationally from zeroed regs.
//  - wdata = write_alu ? alu_out : is_load ? ram_data : imm_data (write_alu has priority).
//  - Write: on posedge clk, if write_en && write_addr!=0, reg[write_addr] <= wdata. Writes to R0 are dropped.
//  - Reads async: raw_x = (addr==0) ? 0 : reg[addr].
//  - Bypass: read_x = wdata when write_en && !write_alu && write_addr==x_addr && write_addr!=0; else raw_x.
//    ALU writes never bypass (avoids comb loop alu_out->read_a->alu_out); ALU operands always use raw_x.
//  - ALU: A = raw_a; B = alu_imm_flag ? imm_data : raw_b. Opcodes:
//    000 ADD {carry,out}=A+B | 001 SUB out=A-B, carry=borrow (A<B unsigned)
//    010 AND | 011 OR | 100 XOR | 101 NOT out=~A | 110 SHL out=A<<1, carry=A[7]
//    111 SHR logical, out=A>>1, carry=A[0]; logic ops and NOT: carry=0.
//  - Arithmetic wraps mod 256 (0xFF+1=0x00, carry=1; 0x00-1=0xFF, carry=1).
//  - alu_zero = (alu_out==0), purely combinational; no flag registers.
//  - Read-modify-write same reg (ra=write_addr, write_alu=1): ALU sees old value; new value visible next cycle.
//  - Single-cycle latency: write visible on raw reads after the capturing edge.
// STRUCTURE
//  - Shared package protocore_pkg: ALU opcode localparams (ADD..SHR), DATA_W, register address width.
//  - Sub-module protocore_alu (combinational: a, b, opcode -> out, zero, carry); regfile and muxes inline.
// TESTING
//  - Write i*0x11 to R1..R15 via imm (write_en=1, write_alu=0, is_load=0); read ra=i, rb=15-i -> matches, R0=00.
//  - Bypass: write_en=1, write_addr=9, imm 0xA4, ra=9 before edge -> read_a=A4; after edge rb=9 -> A4.
//  - R0: write 0xA4 to R0 -> read_a=00 same cycle and read_b=00 after edge.
//  - Load: is_load=1, ram_data=0x6C, write_addr=13 -> R13=6C on both ports.
//  - ADD loop: R1=0, R2=1, ra=1, rb=2, ADD, write_alu=1, wa=1 for 64 cycles -> R1 counts to 0x40, zero=0.
//  - SUB: R2=10, 13 cycles from R1=0x40 -> R1=0xBE (wraps), carry=1 on first borrow; rst_n low mid-run clears all.

Source files
------------

// File: rtl/protocore_pkg.sv
// Shared ProtoCore datapath constants: data width, register file geometry and ALU opcodes.
package protocore_pkg;

    localparam int unsigned DATA_W   = 32'd8;
    localparam int unsigned NUM_REGS = 32'd16;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/protocore_if.sv
// Control/RAM-facing bundle of the ProtoCore datapath: decoder controls in, read data and ALU flags out.
interface protocore_if;
    import protocore_pkg::*;

    logic              write_alu;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic              write_en;
    logic              is_load;
    logic              alu_imm_flag;
    logic [DATA_W-1:0] read_a;
    logic [DATA_W-1:0] read_b;
    logic              alu_zero;
    logic              alu_carry;
    logic [DATA_W-1:0] alu_out;

    modport master (
        output write_alu, alu_opcode, ram_data, imm_data, write_addr,
               ra_addr, rb_addr, write_en, is_load, alu_imm_flag,
        input  read_a, read_b, alu_zero, alu_carry, alu_out
    );

    modport slave (
        input  write_alu, alu_opcode, ram_data, imm_data, write_addr,
               ra_addr, rb_addr, write_en, is_load, alu_imm_flag,
        output read_a, read_b, alu_zero, alu_carry, alu_out
    );

endinterface

// File: rtl/protocore_alu.sv
// Combinational 8-operation ALU; carry holds carry-out, borrow, or the bit shifted out.
module protocore_alu
    import protocore_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    // Zero-extended add/subtract so bit DATA_W is carry (add) or borrow (a < b)
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Operation select
    always_comb begin
        result = {DATA_W{1'b0}};
        carry  = 1'b0;
        case (opcode)
            OP_ADD: {carry, result} = sum_s;
            OP_SUB: {carry, result} = diff_s;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: begin
                result = {DATA_W{1'b0}};
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == {DATA_W{1'b0}});

endmodule

// File: rtl/protocore_datapath.sv
// ProtoCore datapath: 16x8 register file with R0 tied to zero, bypassed async reads, ALU and write-back mux.
module protocore_datapath
    import protocore_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    protocore_if.slave  bus
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] raw_a_s;
    logic [DATA_W-1:0] raw_b_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [DATA_W-1:0] alu_out_s;
    logic              alu_zero_s;
    logic              alu_carry_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] wdata_s;
    logic              wr_valid_s;
    logic              bypass_ok_s;

    assign raw_a_s = (bus.ra_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[bus.ra_addr];
    assign raw_b_s = (bus.rb_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[bus.rb_addr];
    assign alu_b_s = bus.alu_imm_flag ? bus.imm_data : raw_b_s;

    protocore_alu u_alu (
        .a      (raw_a_s),
        .b      (alu_b_s),
        .opcode (bus.alu_opcode),
        .result (alu_out_s),
        .zero   (alu_zero_s),
        .carry  (alu_carry_s)
    );

    // Bypass data is taken from the non-ALU sources only, so no path exists from alu_out back to the read ports
    assign mem_wdata_s = bus.is_load ? bus.ram_data : bus.imm_data;
    assign wdata_s     = bus.write_alu ? alu_out_s : mem_wdata_s;
    assign wr_valid_s  = bus.write_en && (bus.write_addr != {ADDR_W{1'b0}});
    assign bypass_ok_s = wr_valid_s && !bus.write_alu;

    assign bus.read_a    = (bypass_ok_s && (bus.write_addr == bus.ra_addr)) ? mem_wdata_s : raw_a_s;
    assign bus.read_b    = (bypass_ok_s && (bus.write_addr == bus.rb_addr)) ? mem_wdata_s : raw_b_s;
    assign bus.alu_out   = alu_out_s;
    assign bus.alu_zero  = alu_zero_s;
    assign bus.alu_carry = alu_carry_s;

    // Register file write port; R0 writes are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_valid_s) begin
            regs_r[bus.write_addr] <= wdata_s;
        end
    end

endmodule

// File: tb/tb_protocore_datapath.sv
// Self-checking bench for protocore_datapath: directed scenarios plus random traffic against an array model.
module tb_protocore_datapath;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   mdl [16];

    protocore_if bus ();

    protocore_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU: returns {carry, out} from plain integer arithmetic
    function automatic logic [8:0] alu_ref(input int a, input int b, input int op);
        int o;
        int c;
        c = 0;
        case (op)
            0: begin o = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin o = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: o = a & b;
            3: o = a | b;
            4: o = a ^ b;
            5: o = 255 - a;
            6: begin o = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            default: begin o = a / 2; c = a % 2; end
        endcase
        return {c[0], o[7:0]};
    endfunction

    task automatic drive(input bit we, input int wa, input bit wal, input bit ld, input int op,
                         input bit immf, input int imm, input int ram, input int ra, input int rb);
        bus.write_en     = we;
        bus.write_addr   = wa[3:0];
        bus.write_alu    = wal;
        bus.is_load      = ld;
        bus.alu_opcode   = op[2:0];
        bus.alu_imm_flag = immf;
        bus.imm_data     = imm[7:0];
        bus.ram_data     = ram[7:0];
        bus.ra_addr      = ra[3:0];
        bus.rb_addr      = rb[3:0];
    endtask

    // Check all outputs against the model mid-cycle, then clock and update the model
    task automatic cycle(input string tag);
        int a, b, bsel, mdata, wd;
        logic [8:0] r;
        int ea, eb;
        #4;
        a     = (bus.ra_addr == 4'd0) ? 0 : mdl[bus.ra_addr];
        b     = (bus.rb_addr == 4'd0) ? 0 : mdl[bus.rb_addr];
        bsel  = bus.alu_imm_flag ? int'(bus.imm_data) : b;
        r     = alu_ref(a, bsel, int'(bus.alu_opcode));
        mdata = bus.is_load ? int'(bus.ram_data) : int'(bus.imm_data);
        wd    = bus.write_alu ? int'(r[7:0]) : mdata;
        ea = a;
        eb = b;
        if (bus.write_en && !bus.write_alu && bus.write_addr != 4'd0) begin
            if (bus.write_addr == bus.ra_addr) ea = mdata;
            if (bus.write_addr == bus.rb_addr) eb = mdata;
        end
        check_val({tag, "_read_a"}, 32'(bus.read_a), 32'(ea));
        check_val({tag, "_read_b"}, 32'(bus.read_b), 32'(eb));
        check_val({tag, "_alu_out"}, 32'(bus.alu_out), 32'(r[7:0]));
        check_val({tag, "_carry"}, 32'(bus.alu_carry), 32'(r[8]));
        check_val({tag, "_zero"}, 32'(bus.alu_zero), (r[7:0] == 8'd0) ? 32'd1 : 32'd0);
        @(posedge clk);
        if (rst_n && bus.write_en && bus.write_addr != 4'd0) mdl[bus.write_addr] = wd;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        foreach (mdl[i]) mdl[i] = 0;
        rst_n = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 7, 3);
        @(posedge clk);
        #1;
        cycle("reset");
        rst_n = 1'b1;

        // Fill R1..R15 with i*0x11 through the immediate path, then read back
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, i, 1'b0, 1'b0, 0, 1'b0, i * 17, 0, 0, 0);
            cycle("fill");
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, i, 15 - i);
            cycle("readback");
        end
        check_val("r15_const", 32'(bus.read_a), 32'hFF);

        // Bypass on port A, then plain read on port B
        drive(1'b1, 9, 1'b0, 1'b0, 2, 1'b0, 8'hA4, 0, 9, 4);
        #4 check_val("bypass_const", 32'(bus.read_a), 32'hA4);
        #0 cycle("bypass");
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1, 9);
        cycle("after_bypass");

        // R0 writes are dropped and never bypass
        drive(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 8'hA4, 0, 0, 0);
        cycle("r0_write");
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 5, 0);
        cycle("r0_read");

        // RAM load into R13
        drive(1'b1, 13, 1'b0, 1'b1, 0, 1'b0, 8'h11, 8'h6C, 13, 13);
        cycle("load");
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 13, 13);
        cycle("load_read");

        // ADD accumulate: R1 += R2 for 64 cycles
        drive(1'b1, 1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0);
        cycle("add_init1");
        drive(1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 1, 0, 0, 0);
        cycle("add_init2");
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1, 1'b1, 1'b0, 0, 1'b0, 0, 0, 1, 2);
            cycle("add_loop");
        end
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1, 2);
        #4 check_val("add_final", 32'(bus.read_a), 32'h40);
        #0 cycle("add_done");

        // SUB 10 for 13 cycles from 0x40, wrapping through a borrow
        drive(1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 10, 0, 0, 0);
        cycle("sub_init");
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1, 1'b1, 1'b0, 1, 1'b0, 0, 0, 1, 2);
            cycle("sub_loop");
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1, 1'b0, 0, 0, 1, 2);
        #4 check_val("sub_final", 32'(bus.read_a), 32'hBE);
        #0 cycle("sub_done");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            cycle("rand");
        end

        // Asynchronous reset mid-run clears everything
        drive(1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 8'h5A, 0, 1, 15);
        #2 rst_n = 1'b0;
        foreach (mdl[i]) mdl[i] = 0;
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1, 15);
        #1 check_val("async_rst_r1", 32'(bus.read_a), 32'h00);
        #0 cycle("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, i, 15 - i);
            cycle("post_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
